// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: round-robin MII TX arbiter for several frame-former sources.
// Grants one source, pulses its ena, forwards its nibbles with one cycle of
// latency, then holds the inter-frame gap. Watchdogs cover a source that never
// starts (timeout_err) and a frame longer than MAX_NIBBLES (overrun_err).
// Optional feature macro: ETH_TX_ARB_PRIORITY_EN gives channel 0 strict priority
// over the round-robin among channels 1..CHANNELS-1.
module eth_tx_arbiter #(
  parameter int CHANNELS      = 4,
  parameter int DATA_W        = 4,
  parameter int IFG_CYCLES    = 24,
  parameter int START_TIMEOUT = 16,
  parameter int MAX_NIBBLES   = 3044
) (
  input  logic                         clock,
  input  logic                         aclr_n,
  input  logic [CHANNELS-1:0]          req,
  output logic [CHANNELS-1:0]          ena,
  input  logic [CHANNELS-1:0]          src_tx_en,
  input  logic [CHANNELS*DATA_W-1:0]   src_tx_d,
  output logic                         tx_en,
  output logic [DATA_W-1:0]            tx_d,
  output logic [3:0]                   active_ch,
  output logic                         busy,
  output logic                         timeout_err,
  output logic                         overrun_err
);

  typedef enum logic [1:0] {IDLE, START, SEND, GAP} state_t;

  localparam logic [3:0]  LAST_RESET = 4'(CHANNELS - 1);
  localparam logic [7:0]  TIMER_LAST = 8'(START_TIMEOUT - 1);
  localparam logic [7:0]  GAP_LAST   = 8'(IFG_CYCLES - 1);
  localparam logic [11:0] FRAME_MAX  = 12'(MAX_NIBBLES);

  state_t                state_q, state_d;
  logic [3:0]            last_grant_q, last_grant_d;
  logic [3:0]            active_ch_q, active_ch_d;
  logic [11:0]           frame_cnt_q, frame_cnt_d;
  logic [7:0]            timer_q, timer_d;
  logic [7:0]            gap_cnt_q, gap_cnt_d;
  logic [CHANNELS-1:0]   ena_q, ena_d;
  logic                  tx_en_q, tx_en_d;
  logic [DATA_W-1:0]     tx_d_q, tx_d_d;
  logic                  busy_q, busy_d;
  logic                  timeout_q, timeout_d;
  logic                  overrun_q, overrun_d;

  logic [15:0]           req_pad;
  logic [15:0]           src_en_pad;
  logic [DATA_W-1:0]     src_d_arr [16];
  logic                  cur_en;
  logic [DATA_W-1:0]     cur_d;

  logic                  sel_found;
  logic                  sel_upd;
  logic [3:0]            sel_ch;
  logic [4:0]            cand;

  // Widen per-channel inputs to 16 entries so a 4-bit channel index is always in range
  always_comb begin
    req_pad    = 16'(req);
    src_en_pad = 16'(src_tx_en);
    for (int k = 0; k < 16; k++) begin
      src_d_arr[k] = '0;
    end
    for (int k = 0; k < CHANNELS; k++) begin
      src_d_arr[k] = src_tx_d[k*DATA_W +: DATA_W];
    end
  end

  assign cur_en = src_en_pad[active_ch_q];
  assign cur_d  = src_d_arr[active_ch_q];

  // Pick the next channel to grant: first requester after last_grant, wrapping
  always_comb begin
    sel_found = 1'b0;
    sel_upd   = 1'b0;
    sel_ch    = '0;
    cand      = '0;
`ifdef ETH_TX_ARB_PRIORITY_EN
    if (req_pad[0]) begin
      sel_found = 1'b1;
      sel_ch    = 4'd0;
    end else begin
      for (int i = 1; i < CHANNELS; i++) begin
        cand = {1'b0, last_grant_q} + 5'(i);
        if (cand >= 5'(CHANNELS)) begin
          cand = cand - 5'(CHANNELS - 1);
        end
        if (!sel_found && req_pad[cand[3:0]]) begin
          sel_found = 1'b1;
          sel_upd   = 1'b1;
          sel_ch    = cand[3:0];
        end
      end
    end
`else
    for (int i = 1; i <= CHANNELS; i++) begin
      cand = {1'b0, last_grant_q} + 5'(i);
      if (cand >= 5'(CHANNELS)) begin
        cand = cand - 5'(CHANNELS);
      end
      if (!sel_found && req_pad[cand[3:0]]) begin
        sel_found = 1'b1;
        sel_upd   = 1'b1;
        sel_ch    = cand[3:0];
      end
    end
`endif
  end

  // Next-state and registered-output logic for the grant/send/gap sequence
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    active_ch_d  = active_ch_q;
    frame_cnt_d  = frame_cnt_q;
    timer_d      = timer_q;
    gap_cnt_d    = gap_cnt_q;
    ena_d        = '0;
    tx_en_d      = 1'b0;
    tx_d_d       = '0;
    timeout_d    = 1'b0;
    overrun_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          ena_d       = CHANNELS'(16'd1 << sel_ch);
          active_ch_d = sel_ch;
          timer_d     = '0;
          state_d     = START;
          if (sel_upd) begin
            last_grant_d = sel_ch;
          end
        end
      end
      START: begin
        if (cur_en) begin
          tx_en_d     = 1'b1;
          tx_d_d      = cur_d;
          frame_cnt_d = 12'd1;
          state_d     = SEND;
        end else if (timer_q >= TIMER_LAST) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      SEND: begin
        if (!cur_en) begin
          gap_cnt_d = '0;
          state_d   = GAP;
        end else if (frame_cnt_q >= FRAME_MAX) begin
          overrun_d = 1'b1;
          gap_cnt_d = '0;
          state_d   = GAP;
        end else begin
          tx_en_d     = 1'b1;
          tx_d_d      = cur_d;
          frame_cnt_d = frame_cnt_q + 12'd1;
        end
      end
      GAP: begin
        if (cur_en) begin
          gap_cnt_d = '0;
        end else if (gap_cnt_q >= GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset cuts any frame in flight
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q      <= IDLE;
      last_grant_q <= LAST_RESET;
      active_ch_q  <= '0;
      frame_cnt_q  <= '0;
      timer_q      <= '0;
      gap_cnt_q    <= '0;
      ena_q        <= '0;
      tx_en_q      <= 1'b0;
      tx_d_q       <= '0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      active_ch_q  <= active_ch_d;
      frame_cnt_q  <= frame_cnt_d;
      timer_q      <= timer_d;
      gap_cnt_q    <= gap_cnt_d;
      ena_q        <= ena_d;
      tx_en_q      <= tx_en_d;
      tx_d_q       <= tx_d_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
      overrun_q    <= overrun_d;
    end
  end

  assign ena         = ena_q;
  assign tx_en       = tx_en_q;
  assign tx_d        = tx_d_q;
  assign active_ch   = active_ch_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_q;
  assign overrun_err = overrun_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb_eth_tx_arbiter: directed bench for eth_tx_arbiter (CHANNELS=4, MAX_NIBBLES=32).
// Covers single-source forwarding, round-robin order, start timeout, overrun
// truncation, asynchronous reset mid-frame and the channel-0 priority option.
module tb_eth_tx_arbiter;

  localparam int CH  = 4;
  localparam int DW  = 4;
  localparam int IFG = 24;
  localparam int STO = 16;
  localparam int MAXN = 32;

  logic           clock;
  logic           aclr_n;
  logic [CH-1:0]  req;
  logic [CH-1:0]  ena;
  logic [CH-1:0]  src_tx_en;
  logic [CH*DW-1:0] src_tx_d;
  logic           tx_en;
  logic [DW-1:0]  tx_d;
  logic [3:0]     active_ch;
  logic           busy;
  logic           timeout_err;
  logic           overrun_err;

  int compared;
  int mismatched;
  int fairOrder [5];

  eth_tx_arbiter #(
    .CHANNELS(CH), .DATA_W(DW), .IFG_CYCLES(IFG),
    .START_TIMEOUT(STO), .MAX_NIBBLES(MAXN)
  ) dut (
    .clock(clock), .aclr_n(aclr_n), .req(req), .ena(ena),
    .src_tx_en(src_tx_en), .src_tx_d(src_tx_d),
    .tx_en(tx_en), .tx_d(tx_d), .active_ch(active_ch), .busy(busy),
    .timeout_err(timeout_err), .overrun_err(overrun_err)
  );

  // Free-running TX_CLK
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard time limit so the run always terminates
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] time limit reached");
  end

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [3:0] nibOf(input int ch, input int i);
    return 4'((ch * 5 + i * 7 + 3) % 16);
  endfunction

  task automatic applyStimulus(input int ch, input logic en, input logic [3:0] d);
    src_tx_en[ch] = en;
    src_tx_d[ch*DW +: DW] = d;
  endtask

  // Count cycles until busy falls (bounded) and check the idle port
  task automatic waitIdle(input string tag, input int expCycles);
    int cnt;
    cnt = 0;
    while (busy !== 1'b0 && cnt < 100) begin
      tick();
      cnt++;
    end
    checkOutput($sformatf("%s.gapLen", tag), cnt, expCycles);
    checkOutput($sformatf("%s.portIdle", tag), {27'd0, tx_en, tx_d}, 32'd0);
  endtask

  // Grant, forward len nibbles from expCh (with noise on a neighbour), then gap
  task automatic sendFrame(input string tag, input logic [3:0] reqMask, input logic [3:0] reqAfter,
                           input int expCh, input int len);
    int noiseCh;
    noiseCh = expCh ^ 1;
    req = reqMask;
    tick();
    checkOutput($sformatf("%s.ena", tag), ena, 32'(4'b0001 << expCh));
    checkOutput($sformatf("%s.activeCh", tag), active_ch, expCh);
    checkOutput($sformatf("%s.busyRise", tag), busy, 1);
    req = reqAfter;
    tick();
    checkOutput($sformatf("%s.enaPulse", tag), ena, 0);
    for (int i = 0; i < len; i++) begin
      applyStimulus(expCh, 1'b1, nibOf(expCh, i));
      applyStimulus(noiseCh, 1'b1, ~nibOf(expCh, i));
      tick();
      checkOutput($sformatf("%s.nib%0d", tag, i), {27'd0, tx_en, tx_d}, {27'd0, 1'b1, nibOf(expCh, i)});
    end
    src_tx_en = '0;
    src_tx_d  = '0;
    tick();
    checkOutput($sformatf("%s.txFall", tag), {30'd0, tx_en, busy}, 32'b01);
    waitIdle(tag, IFG);
  endtask

  initial begin
    int cnt;
    int overCount;
    compared   = 0;
    mismatched = 0;
`ifdef ETH_TX_ARB_PRIORITY_EN
    fairOrder = '{0, 0, 0, 0, 0};
`else
    fairOrder = '{0, 1, 2, 3, 0};
`endif
    aclr_n    = 1'b1;
    req       = '0;
    src_tx_en = '0;
    src_tx_d  = '0;
    #2 aclr_n = 1'b0;
    tick();
    tick();
    checkOutput("rst.outs", {ena, tx_en, tx_d, active_ch, busy, timeout_err, overrun_err}, 0);
    aclr_n = 1'b1;
    tick();
    checkOutput("rst.idle", {ena, busy}, 0);

    $display("[TB] single source on channel 2");
    sendFrame("single", 4'b0100, 4'b0000, 2, 8);

    $display("[TB] start timeout on channel 1");
    req = 4'b0010;
    tick();
    checkOutput("tmo.ena", ena, 32'b0010);
    req = 4'b0000;
    cnt = 0;
    while (timeout_err !== 1'b1 && cnt < 40) begin
      tick();
      cnt++;
    end
    checkOutput("tmo.delay", cnt, STO);
    checkOutput("tmo.busyLow", busy, 0);
    tick();
    checkOutput("tmo.pulse", timeout_err, 0);
    req = 4'b0100;
    tick();
    checkOutput("tmo.nextEna", ena, 32'b0100);
    req = 4'b0000;
    waitIdle("tmo2", STO);

    $display("[TB] fairness with all channels requesting");
    aclr_n = 1'b0;
    tick();
    aclr_n = 1'b1;
    for (int f = 0; f < 5; f++) begin
      sendFrame($sformatf("fair%0d", f), 4'b1111, (f == 4) ? 4'b0000 : 4'b1111, fairOrder[f], 10);
    end

    $display("[TB] overrun on channel 0");
    req = 4'b0001;
    tick();
    checkOutput("ovr.ena", ena, 32'b0001);
    req = 4'b0000;
    tick();
    overCount = 0;
    for (int i = 0; i < 50; i++) begin
      applyStimulus(0, 1'b1, nibOf(0, i));
      tick();
      if (overrun_err === 1'b1) overCount++;
      if (i < MAXN) begin
        checkOutput($sformatf("ovr.nib%0d", i), {27'd0, tx_en, tx_d}, {27'd0, 1'b1, nibOf(0, i)});
      end else if (i == MAXN) begin
        checkOutput("ovr.cut", {30'd0, tx_en, overrun_err}, 32'b01);
      end
    end
    checkOutput("ovr.pulses", overCount, 1);
    checkOutput("ovr.hold", {30'd0, tx_en, busy}, 32'b01);
    applyStimulus(0, 1'b0, 4'h0);
    waitIdle("ovr", IFG);

    $display("[TB] reset during a frame");
    req = 4'b0010;
    tick();
    checkOutput("rmf.ena", ena, 32'b0010);
    req = 4'b0000;
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1'b1, nibOf(1, i));
      tick();
      checkOutput($sformatf("rmf.nib%0d", i), {27'd0, tx_en, tx_d}, {27'd0, 1'b1, nibOf(1, i)});
    end
    #3 aclr_n = 1'b0;
    #1;
    checkOutput("rmf.async", {ena, tx_en, tx_d, active_ch, busy, timeout_err, overrun_err}, 0);
    src_tx_en = '0;
    src_tx_d  = '0;
    tick();
    aclr_n = 1'b1;
    sendFrame("rmf.after", 4'b1001, 4'b0000, 0, 2);

`ifdef ETH_TX_ARB_PRIORITY_EN
    $display("[TB] channel 0 priority over channel 3");
    sendFrame("prio0", 4'b1001, 4'b1001, 0, 3);
    sendFrame("prio1", 4'b1001, 4'b1000, 0, 3);
    sendFrame("prio3", 4'b1000, 4'b0000, 3, 3);
`else
    $display("[TB] round-robin between channels 0 and 3");
    sendFrame("rr3", 4'b1001, 4'b1001, 3, 3);
    sendFrame("rr0", 4'b1001, 4'b0000, 0, 3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
